biu_bus_responder: RTL and testbench
====================================

// Module: biu_bus_responder
// PURPOSE
//  Target-side end of the BIU external bus: memory/IO responder on addr_bus/rd/wr/ale.
//  Latches the 20-bit physical address on ale, then services one read or write per bus cycle.
//  Accesses go to an internal byte RAM window or a 16-byte IO register file.
//  Inserts programmable wait states (ready low) and flags unmapped accesses.
//  Sits opposite biu_top in the system bench and SoC top.
// PARAMETERS
//  ADDR_W       20        physical address width
//  DATA_W       8         bus data width
//  MEM_AW       12        RAM window address bits (4 KiB)
//  MEM_BASE     20'h12000 RAM window base; must be aligned to 2**MEM_AW
//  IO_AW        4         IO register file address bits (16 ports)
//  WAIT_STATES  1         wait cycles per access, 0..7
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  addr_bus   in   ADDR_W  physical address from BIU; valid while ale=1
//  ale        in   1       address latch enable, active-high
//  m_io       in   1       1=memory, 0=IO space; sampled with ale
//  rd         in   1       read strobe, active-high
//  wr         in   1       write strobe, active-high
//  data_in    in   DATA_W  write data from BIU; sampled with wr
//  data_out   out  DATA_W  read data to BIU
//  data_valid out  1       one-cycle pulse: data_out holds read data
//  ready      out  1       0 = bus cycle in progress (wait), 1 = idle/complete
//  bus_err    out  1       one-cycle pulse: unmapped or illegal access
// BEHAVIOUR
//  Reset: state IDLE; data_out=0, data_valid=0, bus_err=0, ready=1, addr_vld=0.
//   RAM and IO registers are not cleared.
//  FSM states:
//   IDLE: ale=1 -> latch addr_bus, m_io; set addr_vld; go ADDR.
//   ADDR: wait for a strobe; ale=1 re-latches the address.
//   WAIT: count WAIT_STATES cycles; ready=0.
//   XFER: one cycle; perform access; ready=1; pulse data_valid or bus_err; -> IDLE.
//  Transitions:
//   ADDR, rd^wr=1 -> capture cycle type and data_in; go WAIT (XFER if WAIT_STATES=0).
//   Strobe is sampled once. rd/wr need not be held (BIU pulses them for one cycle).
//   ready falls after the edge on which the strobe is sampled and stays low until XFER.
//  Latency: strobe sampled at edge N -> data_valid/bus_err high after edge N+1+WAIT_STATES,
//   for exactly one cycle. data_out holds its value until the next read completes.
//  Decode:
//   m_io=1: hit when addr[ADDR_W-1:MEM_AW]==MEM_BASE[ADDR_W-1:MEM_AW]; index addr[MEM_AW-1:0].
//   m_io=0: hit when addr[ADDR_W-1:IO_AW]==0; index addr[IO_AW-1:0].
//  Miss: read returns 8'hFF with data_valid=1 plus bus_err=1; write is dropped, bus_err=1.
//  rd&wr both 1 in ADDR: no access; XFER pulses bus_err only; data_out unchanged.
//  Strobe in IDLE without a prior ale, or with addr_vld=0: treated as a miss
//   (bus_err at normal latency). Address is not inferred.
//  Back-to-back cycles: ale on the cycle right after XFER is accepted (no dead cycle).
//  ale during WAIT: aborts the pending access (no write, no pulses), re-latches, goes ADDR.
//  Strobes during WAIT/XFER are ignored.
//  Reset mid-cycle: next cycle IDLE with reset outputs; a pending write is not performed.
// STRUCTURE
//  biu_pkg holds: ADDR_W/DATA_W defaults, resp_state_e enum (IDLE, ADDR, WAIT, XFER),
//   and the phys_addr(seg,off) = {seg,4'h0}+off function shared with the bus tests.
//  Sub-module biu_resp_ram: single-port synchronous byte RAM, 2**MEM_AW deep, 1-cycle read.
//   Read is issued at the last WAIT cycle (at ADDR exit when WAIT_STATES=0).
//  IO register file, decode, wait counter and FSM are in this module.
// TESTING
//  1 Memory write/read at phys_addr(16'h1234,16'h00A1)=0x123E1, WAIT_STATES=1:
//    ale; wr with data_in=8'hAA -> no error; ale; rd -> data_out=8'hAA,
//    data_valid high after edge N+2, ready low for 2 cycles.
//  2 Unmapped read at 0x00010 with m_io=1 -> data_out=8'hFF, data_valid=1, bus_err=1,
//    same latency; a write to 0x13000 is dropped and pulses bus_err.
//  3 IO: m_io=0, addr 0x00005, write 8'h3C, read back -> 8'h3C.
//    Memory read at 0x12005 is unchanged. IO addr 0x00015 -> bus_err.
//  4 rd=wr=1 at 0x12010 with data_in=8'h55 -> bus_err pulse only;
//    a subsequent read of 0x12010 returns the old value.
//  5 Assert rst in WAIT of a write of 8'h77 to 0x123E1 -> next cycle ready=1,
//    data_valid=0, bus_err=0; a read of 0x123E1 still returns 8'hAA.
//  6 ale with 0x12020 during WAIT of a read at 0x123E1 -> no data_valid for the first access.
//    The following rd returns mem[0x12020]. Repeat with WAIT_STATES=0 and =3
//    to check latency N+1 and N+4.

Source files
------------

// File: rtl/biu_pkg.sv
// biu_pkg: shared BIU bus widths, responder state type and segment:offset address helper
package biu_pkg;
  localparam int BIU_ADDR_W = 20;
  localparam int BIU_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, ADDR, WAIT, XFER} resp_state_e;
  function automatic logic [BIU_ADDR_W-1:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
    return {seg, 4'h0} + {4'h0, off};
  endfunction
endpackage

// File: rtl/biu_resp_ram.sv
// biu_resp_ram: single-port synchronous byte RAM with one-cycle read latency
module biu_resp_ram #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      else rdata <= mem[addr];
    end
endmodule

// File: rtl/biu_bus_responder.sv
// biu_bus_responder: target-side BIU bus responder with RAM window, IO registers and wait states
module biu_bus_responder
  import biu_pkg::*;
#(
  parameter int                ADDR_W      = BIU_ADDR_W,
  parameter int                DATA_W      = BIU_DATA_W,
  parameter int                MEM_AW      = 12,
  parameter logic [ADDR_W-1:0] MEM_BASE    = 20'h12000,
  parameter int                IO_AW       = 4,
  parameter int                WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_bus,
  input  logic              ale,
  input  logic              m_io,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              ready,
  output logic              bus_err
);
  resp_state_e state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, ram_rdata;
  logic [DATA_W-1:0] io_regs [2**IO_AW];
  logic [2:0] wcnt;
  logic mio_q, addr_vld, rd_q, wr_q, hit_q;
  logic strobe, dec_hit, go_xfer, do_wr, ram_we;
  assign strobe = rd | wr;
  assign dec_hit = addr_vld && (mio_q ? addr_q[ADDR_W-1:MEM_AW] == MEM_BASE[ADDR_W-1:MEM_AW]
                                      : addr_q[ADDR_W-1:IO_AW] == '0);
  // RAM read is launched on the edge that enters XFER so the byte is ready during XFER
  assign go_xfer = !ale && (WAIT_STATES == 0 ? (state == IDLE || state == ADDR) && strobe
                                             : state == WAIT && wcnt == 3'(WAIT_STATES - 1));
  assign do_wr = !rst && state == XFER && wr_q && !rd_q && hit_q;
  assign ram_we = do_wr && mio_q;
  biu_resp_ram #(.AW(MEM_AW), .DW(DATA_W)) u_ram (
    .clk(clk),
    .en(go_xfer || ram_we),
    .we(ram_we),
    .addr(addr_q[MEM_AW-1:0]),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );
  always_ff @(posedge clk)
    if (do_wr && !mio_q) io_regs[addr_q[IO_AW-1:0]] <= wdata_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data_out <= '0;
      data_valid <= 1'b0;
      bus_err <= 1'b0;
      ready <= 1'b1;
      addr_vld <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE, ADDR: begin
          if (ale) begin
            addr_q <= addr_bus;
            mio_q <= m_io;
            addr_vld <= 1'b1;
            state <= ADDR;
          end else if (strobe) begin
            rd_q <= rd;
            wr_q <= wr;
            wdata_q <= data_in;
            hit_q <= dec_hit;
            addr_vld <= 1'b0;
            wcnt <= '0;
            ready <= 1'b0;
            state <= go_xfer ? XFER : WAIT;
          end
        end
        WAIT: begin
          if (ale) begin
            addr_q <= addr_bus;
            mio_q <= m_io;
            addr_vld <= 1'b1;
            ready <= 1'b1;
            state <= ADDR;
          end else begin
            wcnt <= wcnt + 3'd1;
            if (go_xfer) state <= XFER;
          end
        end
        XFER: begin
          state <= IDLE;
          ready <= 1'b1;
          bus_err <= (rd_q && wr_q) || !hit_q;
          data_valid <= rd_q && !wr_q;
          if (rd_q && !wr_q)
            data_out <= !hit_q ? '1 : mio_q ? ram_rdata : io_regs[addr_q[IO_AW-1:0]];
        end
      endcase
    end
  end
endmodule

// File: tb/tb_biu_bus_responder.sv
// tb_biu_bus_responder: three responders (0/1/3 wait states) on one bus vs a timeline reference model
module tb_biu_bus_responder;
  import biu_pkg::*;
  localparam int NI = 3;
  logic clk = 0, rst = 1, ale = 0, m_io = 0, rd = 0, wr = 0;
  logic [19:0] addr_bus = '0;
  logic [7:0] data_in = '0;
  logic [7:0] dout [NI];
  logic dv [NI], rdy [NI], err [NI];
  int vectors = 0, miscompares = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  biu_bus_responder #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .addr_bus(addr_bus), .ale(ale), .m_io(m_io),
    .rd(rd), .wr(wr), .data_in(data_in), .data_out(dout[0]), .data_valid(dv[0]), .ready(rdy[0]), .bus_err(err[0]));
  biu_bus_responder #(.WAIT_STATES(1)) dut1 (.clk(clk), .rst(rst), .addr_bus(addr_bus), .ale(ale), .m_io(m_io),
    .rd(rd), .wr(wr), .data_in(data_in), .data_out(dout[1]), .data_valid(dv[1]), .ready(rdy[1]), .bus_err(err[1]));
  biu_bus_responder #(.WAIT_STATES(3)) dut3 (.clk(clk), .rst(rst), .addr_bus(addr_bus), .ale(ale), .m_io(m_io),
    .rd(rd), .wr(wr), .data_in(data_in), .data_out(dout[2]), .data_valid(dv[2]), .ready(rdy[2]), .bus_err(err[2]));
  function automatic int ws_of(int i);
    return i == 0 ? 0 : i == 1 ? 1 : 3;
  endfunction
  function automatic bit mapped(logic [19:0] a, bit mio);
    return mio ? a[19:12] == 8'h12 : a[19:4] == 16'h0;
  endfunction
  // model: each access resolves at strobe edge + 1 + wait states; ale before then aborts it
  bit pend [NI], lat [NI], l_mio [NI], p_rd [NI], p_wr [NI], p_hit [NI], p_mio [NI];
  int due [NI];
  logic [19:0] l_addr [NI], p_addr [NI];
  logic [7:0] p_din [NI];
  logic [7:0] mem_m [NI][4096];
  bit mem_k [NI][4096];
  logic [7:0] io_m [NI][16];
  bit io_k [NI][16];
  logic [7:0] e_dout [NI];
  bit e_dk [NI], e_dv [NI], e_err [NI], e_rdy [NI];
  initial forever begin
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      e_dv[i] = 0;
      e_err[i] = 0;
      if (rst) begin
        pend[i] = 0; lat[i] = 0; e_rdy[i] = 1; e_dout[i] = 0; e_dk[i] = 1;
      end else if (pend[i] && cyc == due[i]) begin
        pend[i] = 0;
        e_rdy[i] = 1;
        if (p_rd[i] && p_wr[i]) e_err[i] = 1;
        else if (p_rd[i]) begin
          e_dv[i] = 1;
          if (!p_hit[i]) begin e_dout[i] = 8'hFF; e_dk[i] = 1; e_err[i] = 1; end
          else if (p_mio[i]) begin e_dout[i] = mem_m[i][p_addr[i][11:0]]; e_dk[i] = mem_k[i][p_addr[i][11:0]]; end
          else begin e_dout[i] = io_m[i][p_addr[i][3:0]]; e_dk[i] = io_k[i][p_addr[i][3:0]]; end
        end else if (!p_hit[i]) e_err[i] = 1;
        else if (p_mio[i]) begin mem_m[i][p_addr[i][11:0]] = p_din[i]; mem_k[i][p_addr[i][11:0]] = 1; end
        else begin io_m[i][p_addr[i][3:0]] = p_din[i]; io_k[i][p_addr[i][3:0]] = 1; end
      end else if (ale) begin
        pend[i] = 0; lat[i] = 1; l_addr[i] = addr_bus; l_mio[i] = m_io; e_rdy[i] = 1;
      end else if (!pend[i] && (rd || wr)) begin
        pend[i] = 1; due[i] = cyc + 1 + ws_of(i);
        p_rd[i] = rd; p_wr[i] = wr; p_din[i] = data_in;
        p_addr[i] = l_addr[i]; p_mio[i] = l_mio[i];
        p_hit[i] = lat[i] && mapped(l_addr[i], l_mio[i]);
        lat[i] = 0; e_rdy[i] = 0;
      end
    end
    cyc++;
  end
  task automatic chk(string nm, int i, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s ws=%0d cyc=%0d: got %h expected %h", nm, ws_of(i), cyc, act, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (cyc > 0)
      for (int i = 0; i < NI; i++) begin
        chk("ready", i, 8'(rdy[i]), 8'(e_rdy[i]));
        chk("data_valid", i, 8'(dv[i]), 8'(e_dv[i]));
        chk("bus_err", i, 8'(err[i]), 8'(e_err[i]));
        if (e_dk[i]) chk("data_out", i, dout[i], e_dout[i]);
      end
  end
  task automatic step(bit a_l, bit r, bit w, logic [19:0] a, bit mio, logic [7:0] d);
    ale = a_l; rd = r; wr = w; addr_bus = a; m_io = mio; data_in = d;
    @(negedge clk);
    ale = 0; rd = 0; wr = 0;
  endtask
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic access(logic [19:0] a, bit mio, bit r, bit w, logic [7:0] d);
    step(1, 0, 0, a, mio, 8'h00);
    step(0, r, w, a, mio, d);
    idle(4);
  endtask
  task automatic lit_tail(logic [7:0] x0, bit e0, logic [7:0] x, bit e);
    chk("lit_rdy_wait", 1, 8'(rdy[1]), 8'h00);
    chk("lit_dv_none", 1, 8'(dv[1]), 8'h00);
    idle(1);
    chk("lit_dv_ws0", 0, 8'(dv[0]), 8'h01);
    chk("lit_dout_ws0", 0, dout[0], x0);
    chk("lit_err_ws0", 0, 8'(err[0]), 8'(e0));
    chk("lit_rdy_wait2", 1, 8'(rdy[1]), 8'h00);
    chk("lit_dv_early", 1, 8'(dv[1]), 8'h00);
    idle(1);
    chk("lit_dv_ws1", 1, 8'(dv[1]), 8'h01);
    chk("lit_dout_ws1", 1, dout[1], x);
    chk("lit_err_ws1", 1, 8'(err[1]), 8'(e));
    chk("lit_rdy_done", 1, 8'(rdy[1]), 8'h01);
    idle(2);
    chk("lit_dv_ws3", 2, 8'(dv[2]), 8'h01);
    chk("lit_dout_ws3", 2, dout[2], x);
    idle(1);
  endtask
  task automatic lit_read(logic [19:0] a, bit mio, logic [7:0] x, bit e);
    step(1, 0, 0, a, mio, 8'h00);
    step(0, 1, 0, a, mio, 8'h00);
    lit_tail(x, e, x, e);
  endtask
  logic [19:0] a0, ra;
  bit rm, r, w, noale;
  int k;
  initial begin
    a0 = phys_addr(16'h1234, 16'h00A1);
    idle(2);
    rst = 0;
    chk("rst_ready", 1, 8'(rdy[1]), 8'h01);
    chk("rst_dv", 1, 8'(dv[1]), 8'h00);
    chk("rst_err", 1, 8'(err[1]), 8'h00);
    chk("rst_dout", 1, dout[1], 8'h00);
    access(a0, 1, 0, 1, 8'hAA);
    lit_read(a0, 1, 8'hAA, 0);
    lit_read(20'h00010, 1, 8'hFF, 1);
    access(20'h13000, 1, 0, 1, 8'h5A);
    access(20'h12005, 1, 0, 1, 8'h11);
    access(20'h00005, 0, 0, 1, 8'h3C);
    lit_read(20'h00005, 0, 8'h3C, 0);
    lit_read(20'h12005, 1, 8'h11, 0);
    lit_read(20'h00015, 0, 8'hFF, 1);
    access(20'h12010, 1, 0, 1, 8'h99);
    access(20'h12010, 1, 1, 1, 8'h55);
    lit_read(20'h12010, 1, 8'h99, 0);
    step(1, 0, 0, a0, 1, 8'h00);
    step(0, 0, 1, a0, 1, 8'h77);
    rst = 1;
    idle(1);
    rst = 0;
    chk("rst_mid_ready", 1, 8'(rdy[1]), 8'h01);
    chk("rst_mid_dv", 1, 8'(dv[1]), 8'h00);
    chk("rst_mid_err", 2, 8'(err[2]), 8'h00);
    idle(1);
    lit_read(a0, 1, 8'hAA, 0);
    access(20'h12020, 1, 0, 1, 8'h42);
    step(1, 0, 0, a0, 1, 8'h00);
    step(0, 1, 0, a0, 1, 8'h00);
    step(1, 0, 0, 20'h12020, 1, 8'h00);
    step(0, 1, 0, 20'h12020, 1, 8'h00);
    lit_tail(8'hFF, 1, 8'h42, 0);
    for (int t = 0; t < 400; t++) begin
      k = $urandom_range(0, 3);
      rm = k < 2;
      ra = k == 0 ? 20'h12000 | 20'($urandom_range(0, 63)) :
           k == 1 ? 20'($urandom) : k == 2 ? 20'($urandom_range(0, 15)) : 20'($urandom_range(16, 300));
      if (k == 1 && ra[19:12] == 8'h12) ra[19] = 1'b1;
      k = $urandom_range(0, 9);
      r = k < 5 || k == 9;
      w = k >= 4;
      noale = $urandom_range(0, 19) == 0;
      idle($urandom_range(0, 1));
      if (!noale) step(1, 0, 0, ra, rm, 8'h00);
      if ($urandom_range(0, 3) == 0) idle(1);
      step(0, r, w, ra, rm, 8'($urandom));
      k = $urandom_range(0, 9);
      if (k == 0) begin
        step(1, 0, 0, 20'h12000 | 20'($urandom_range(0, 63)), 1, 8'h00);
        step(0, 1, 0, ra, rm, 8'h00);
      end else if (k == 1) begin
        rst = 1;
        idle(1);
        rst = 0;
      end
      idle(4);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
